// File: rtl/types_pkg.sv
// Shared core types: data word, register index, decoded instruction record,
// and the debug register arbiter FSM state encoding.
package types_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Decoded instruction as seen by the register file ports.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        reg_idx_t   rs1;
        reg_idx_t   rs2;
        reg_idx_t   rd;
        logic       has_rd;
        word_t      imm;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dbg_arb_state_t;

endpackage : types_pkg

// File: rtl/debug_reg_arbiter.sv
// Debug register arbiter: stalls the core, lets in-flight writeback drain,
// then performs one debug read or write on the register file ports and
// returns the result through a valid/ready response channel.
// Optional feature: DEBUG_REG_ARBITER_X0_GUARD_EN makes address 0 read as
// zero and suppresses debug writes to it.
module debug_reg_arbiter
    import types_pkg::*;
#(
    parameter int size         = 32,
    parameter int drain_cycles = 2,
    localparam int AW          = $clog2(size)
) (
    input  logic         clk,
    input  logic         reset,
    // core side
    input  logic         core_enable,
    input  instruction_t core_src_instr,
    input  instruction_t core_dest_instr,
    input  word_t        core_xd,
    output logic         core_stall,
    // register file side
    output logic         rf_enable,
    output instruction_t rf_src_instr,
    output instruction_t rf_dest_instr,
    output word_t        rf_xd,
    input  word_t        rf_xs1,
    // debug side
    input  logic         dbg_valid,
    output logic         dbg_ready,
    input  logic         dbg_write,
    input  logic [AW-1:0] dbg_addr,
    input  word_t        dbg_wdata,
    output logic         dbg_rvalid,
    input  logic         dbg_rready,
    output word_t        dbg_rdata
);

    localparam int          CNT_W      = 4;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(drain_cycles - 1);

`ifdef DEBUG_REG_ARBITER_X0_GUARD_EN
    localparam logic X0_GUARD = 1'b1;
`else
    localparam logic X0_GUARD = 1'b0;
`endif

    dbg_arb_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    word_t            rdata_q, rdata_d;
    logic             x0_hit_s;

    assign x0_hit_s  = X0_GUARD && (dbg_addr == {AW{1'b0}});
    assign dbg_rdata = rdata_q;

    // Next-state, drain counter and response data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (dbg_valid) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (x0_hit_s) begin
                    rdata_d = {XLEN{1'b0}};
                end else if (dbg_write) begin
                    rdata_d = dbg_wdata;
                end else begin
                    rdata_d = rf_xs1;
                end
            end
            RESP: begin
                if (dbg_rready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and response data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            rdata_q <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Port muxing: core passes through except in ACCESS, where the debug
    // request owns the register file. A write coinciding with reset is dropped.
    always_comb begin
        rf_enable     = core_enable;
        rf_src_instr  = core_src_instr;
        rf_dest_instr = core_dest_instr;
        rf_xd         = core_xd;
        core_stall    = 1'b0;
        dbg_ready     = 1'b0;
        dbg_rvalid    = 1'b0;
        case (state_q)
            IDLE: begin
                core_stall = 1'b0;
            end
            DRAIN: begin
                core_stall = 1'b1;
            end
            ACCESS: begin
                core_stall    = 1'b1;
                dbg_ready     = 1'b1;
                rf_enable     = 1'b0;
                rf_src_instr  = '0;
                rf_dest_instr = '0;
                rf_xd         = {XLEN{1'b0}};
                if (dbg_write) begin
                    rf_enable            = ~reset & ~x0_hit_s;
                    rf_dest_instr.has_rd = 1'b1;
                    rf_dest_instr.rd     = REG_IDX_W'(dbg_addr);
                    rf_xd                = dbg_wdata;
                end else begin
                    rf_src_instr.rs1 = REG_IDX_W'(dbg_addr);
                end
            end
            RESP: begin
                core_stall = 1'b1;
                dbg_rvalid = 1'b1;
            end
            default: begin
                core_stall = 1'b1;
            end
        endcase
    end

endmodule : debug_reg_arbiter

// File: tb/tb_debug_reg_arbiter.sv
// Directed self-checking bench for debug_reg_arbiter (drain_cycles = 2).
// Compile with DEBUG_REG_ARBITER_X0_GUARD_EN to exercise the address-0 guard.
module tb_debug_reg_arbiter;
    import types_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         core_enable;
    instruction_t core_src_instr, core_dest_instr;
    word_t        core_xd;
    logic         core_stall;
    logic         rf_enable;
    instruction_t rf_src_instr, rf_dest_instr;
    word_t        rf_xd, rf_xs1;
    logic         dbg_valid, dbg_ready, dbg_write;
    logic [4:0]   dbg_addr;
    word_t        dbg_wdata;
    logic         dbg_rvalid, dbg_rready;
    word_t        dbg_rdata;

    int checks = 0;
    int errors = 0;
    instruction_t exp_i;

    word_t regs [32];

    debug_reg_arbiter #(.size(32), .drain_cycles(2)) dut (
        .clk(clk), .reset(reset),
        .core_enable(core_enable), .core_src_instr(core_src_instr),
        .core_dest_instr(core_dest_instr), .core_xd(core_xd), .core_stall(core_stall),
        .rf_enable(rf_enable), .rf_src_instr(rf_src_instr), .rf_dest_instr(rf_dest_instr),
        .rf_xd(rf_xd), .rf_xs1(rf_xs1),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_write(dbg_write),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rvalid(dbg_rvalid),
        .dbg_rready(dbg_rready), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    // Register file model driven by the rf_* ports.
    always @(posedge clk) begin
        if (rf_enable && rf_dest_instr.has_rd) regs[rf_dest_instr.rd] <= rf_xd;
    end
    assign rf_xs1 = regs[rf_src_instr.rs1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic core_wr(input logic [4:0] r, input word_t v);
        core_enable = 1'b1;
        core_dest_instr = '0;
        core_dest_instr.has_rd = 1'b1;
        core_dest_instr.rd = r;
        core_xd = v;
        step();
        core_enable = 1'b0;
        core_dest_instr = '0;
        core_xd = 32'h0;
    endtask

    // Complete debug transaction with fixed 2-cycle drain.
    task automatic dbg_txn(input string tag, input logic w, input logic [4:0] a,
                           input word_t d, input logic exp_en, input word_t exp_rd);
        dbg_valid = 1'b1; dbg_write = w; dbg_addr = a; dbg_wdata = d;
        step(); step(); step();
        #1;
        chk({tag, "_ready"}, dbg_ready, 1'b1);
        chk({tag, "_rf_en"}, rf_enable, exp_en);
        step();
        dbg_valid = 1'b0;
        #1;
        chk({tag, "_rdata"}, dbg_rdata, exp_rd);
        dbg_rready = 1'b1;
        step();
        dbg_rready = 1'b0;
        #1;
        chk({tag, "_rvalid_low"}, dbg_rvalid, 1'b0);
    endtask

    initial begin
        reset = 1'b1; core_enable = 1'b0; core_src_instr = '0; core_dest_instr = '0;
        core_xd = 32'h0; dbg_valid = 1'b0; dbg_write = 1'b0; dbg_addr = 5'd0;
        dbg_wdata = 32'h0; dbg_rready = 1'b0;
        step(); step();
        #1;
        chk("rst_stall", core_stall, 1'b0);
        chk("rst_ready", dbg_ready, 1'b0);
        chk("rst_rvalid", dbg_rvalid, 1'b0);
        chk("rst_rdata", dbg_rdata, 32'h0);
        reset = 1'b0;
        step();

        // Preload through IDLE pass-through.
        core_enable = 1'b1; core_dest_instr = '0; core_dest_instr.has_rd = 1'b1;
        core_dest_instr.rd = 5'd5; core_xd = 32'h1234_5678;
        #1;
        chk("idle_pass_en", rf_enable, 1'b1);
        chk("idle_pass_xd", rf_xd, 32'h1234_5678);
        step();
        core_enable = 1'b0; core_dest_instr = '0; core_xd = 32'h0;
        core_wr(5'd9, 32'h0000_0099);

        // Read of x5: ready at cycle 3, response at cycle 4.
        dbg_valid = 1'b1; dbg_write = 1'b0; dbg_addr = 5'd5;
        #1;
        chk("rd_c0_stall", core_stall, 1'b0);
        step(); #1;
        chk("rd_c1_stall", core_stall, 1'b1);
        chk("rd_c1_ready", dbg_ready, 1'b0);
        step(); #1;
        chk("rd_c2_ready", dbg_ready, 1'b0);
        step(); #1;
        chk("rd_c3_ready", dbg_ready, 1'b1);
        chk("rd_c3_rf_en", rf_enable, 1'b0);
        exp_i = '0; exp_i.rs1 = 5'd5;
        chk("rd_c3_src", rf_src_instr, exp_i);
        chk("rd_c3_dest", rf_dest_instr, 65'h0);
        step();
        dbg_valid = 1'b0;
        #1;
        chk("rd_c4_rvalid", dbg_rvalid, 1'b1);
        chk("rd_c4_rdata", dbg_rdata, 32'h1234_5678);
        chk("rd_c4_ready", dbg_ready, 1'b0);
        dbg_rready = 1'b1;
        step();
        dbg_rready = 1'b0;
        #1;
        chk("rd_c5_rvalid", dbg_rvalid, 1'b0);
        chk("rd_c5_stall", core_stall, 1'b0);

        // Write 0xDEADBEEF to x7, then hold the response for 5 cycles.
        dbg_valid = 1'b1; dbg_write = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'hDEAD_BEEF;
        step(); #1;
        chk("wr_c1_stall", core_stall, 1'b1);
        step(); step(); #1;
        chk("wr_c3_ready", dbg_ready, 1'b1);
        chk("wr_c3_rf_en", rf_enable, 1'b1);
        exp_i = '0; exp_i.has_rd = 1'b1; exp_i.rd = 5'd7;
        chk("wr_c3_dest", rf_dest_instr, exp_i);
        chk("wr_c3_xd", rf_xd, 32'hDEAD_BEEF);
        step();
        dbg_valid = 1'b0;
        #1;
        chk("wr_reg7", regs[7], 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid", dbg_rvalid, 1'b1);
            chk("bp_rdata", dbg_rdata, 32'hDEAD_BEEF);
            chk("bp_stall", core_stall, 1'b1);
            step();
        end
        // Release; new request presented in the exit cycle must wait one IDLE cycle.
        dbg_rready = 1'b1; dbg_valid = 1'b1; dbg_write = 1'b1; dbg_addr = 5'd3;
        dbg_wdata = 32'h0000_0022;
        #1;
        chk("bp_exit_rvalid", dbg_rvalid, 1'b1);
        step();
        dbg_rready = 1'b0;
        // Contention: core writes x3=0x11 in the cycle dbg_valid is seen in IDLE.
        core_enable = 1'b1; core_dest_instr = '0; core_dest_instr.has_rd = 1'b1;
        core_dest_instr.rd = 5'd3; core_xd = 32'h0000_0011;
        #1;
        chk("gap_rvalid", dbg_rvalid, 1'b0);
        chk("gap_stall", core_stall, 1'b0);
        chk("ct_c0_rf_en", rf_enable, 1'b1);
        step();
        // DRAIN: in-flight writeback of x4 still passes through.
        core_dest_instr.rd = 5'd4; core_xd = 32'h0000_0044;
        #1;
        chk("ct_c1_stall", core_stall, 1'b1);
        chk("ct_c1_reg3", regs[3], 32'h0000_0011);
        chk("ct_c1_pass_xd", rf_xd, 32'h0000_0044);
        step();
        // Request withdrawn during DRAIN; ACCESS still happens.
        core_enable = 1'b0; core_dest_instr = '0; core_xd = 32'h0; dbg_valid = 1'b0;
        step();
        // ACCESS: a core write attempt is masked.
        core_enable = 1'b1; core_dest_instr = '0; core_dest_instr.has_rd = 1'b1;
        core_dest_instr.rd = 5'd4; core_xd = 32'h0000_0055;
        #1;
        chk("ct_c3_ready", dbg_ready, 1'b1);
        chk("ct_c3_xd", rf_xd, 32'h0000_0022);
        exp_i = '0; exp_i.has_rd = 1'b1; exp_i.rd = 5'd3;
        chk("ct_c3_dest", rf_dest_instr, exp_i);
        step();
        core_enable = 1'b0; core_dest_instr = '0; core_xd = 32'h0;
        #1;
        chk("ct_reg3", regs[3], 32'h0000_0022);
        chk("ct_reg4", regs[4], 32'h0000_0044);
        dbg_rready = 1'b1;
        step();
        dbg_rready = 1'b0;

        // Reset coinciding with ACCESS of a write to x9.
        dbg_valid = 1'b1; dbg_write = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h0000_0BAD;
        step(); step(); step();
        reset = 1'b1; dbg_valid = 1'b0;
        #1;
        chk("rs_acc_rf_en", rf_enable, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("rs_reg9", regs[9], 32'h0000_0099);
        chk("rs_stall", core_stall, 1'b0);
        chk("rs_ready", dbg_ready, 1'b0);
        chk("rs_rvalid", dbg_rvalid, 1'b0);
        chk("rs_rdata", dbg_rdata, 32'h0);
        step();
        // Reset left no trace: x9 readable with its old value.
        dbg_txn("rs_rd9", 1'b0, 5'd9, 32'h0, 1'b0, 32'h0000_0099);

        // Address 0 handling.
`ifdef DEBUG_REG_ARBITER_X0_GUARD_EN
        dbg_txn("x0_wr", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h0);
        dbg_txn("x0_rd", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
`else
        dbg_txn("x0_wr", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
        dbg_txn("x0_rd", 1'b0, 5'd0, 32'h0, 1'b0, 32'hFFFF_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_debug_reg_arbiter

// File: doc/debug_reg_arbiter.md
DEBUG_REG_ARBITER -- requirements
Module: debug_reg_arbiter

Interface
REQ-001 Parameter: size, 32, number of architectural registers; the debug address width is $clog2(size).
REQ-002 Parameter: drain_cycles, 2, cycles the core is held stalled before a debug access proceeds; range 1..15.
REQ-003 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Core-side ports SHALL be: core_enable in 1; core_src_instr in instruction_t; core_dest_instr in instruction_t; core_xd in word_t; core_stall out 1.
REQ-006 Register-file-side ports SHALL be: rf_enable out 1; rf_src_instr out instruction_t; rf_dest_instr out instruction_t; rf_xd out word_t; rf_xs1 in word_t.
REQ-007 Debug-side ports SHALL be: dbg_valid in 1; dbg_ready out 1; dbg_write in 1; dbg_addr in $clog2(size); dbg_wdata in word_t; dbg_rvalid out 1; dbg_rready in 1; dbg_rdata out word_t.

Function
REQ-008 FSM states SHALL be IDLE, DRAIN, ACCESS and RESP.
REQ-009 IDLE: pass core_* straight to rf_*; core_stall=0; dbg_ready=0; dbg_rvalid=0; dbg_valid=1 -> DRAIN, loading the drain counter with drain_cycles-1.
REQ-010 DRAIN: core_stall=1; core writes still pass through (in-flight writeback completes); counter decrements each cycle; at 0 -> ACCESS.
REQ-011 ACCESS (exactly 1 cycle): core_stall=1; core_enable masked; dbg_ready=1; dbg_addr, dbg_write and dbg_wdata sampled in this cycle.
REQ-012 ACCESS read: rf_src_instr.rs1=dbg_addr; rf_enable=0; rf_xs1 captured into the dbg_rdata register.
REQ-013 ACCESS write: rf_enable=1; rf_dest_instr.has_rd=1; rf_dest_instr.rd=dbg_addr; rf_xd=dbg_wdata; dbg_rdata register loaded with dbg_wdata as echo.
REQ-014 All instruction_t fields not named in REQ-012/013 SHALL be driven to zero during ACCESS.
REQ-015 ACCESS -> RESP unconditionally; RESP: dbg_rvalid=1; dbg_rdata stable; core_stall=1; dbg_rready=1 -> IDLE.
REQ-016 dbg_rvalid SHALL fall in the cycle after the handshake; a new request is not accepted in the same cycle as RESP exit (minimum 1 IDLE cycle).
REQ-017 If dbg_valid drops during DRAIN, the FSM SHALL still complete ACCESS using the values present in the ACCESS cycle (request withdrawal is a protocol violation, no recovery logic).
REQ-018 Latency from dbg_valid rising in IDLE to dbg_ready SHALL be drain_cycles+1 cycles; dbg_rvalid follows 1 cycle later.
REQ-019 A debug access SHALL never take place while a core write is passed to rf_* in the same cycle.

Reset
REQ-020 Reset SHALL force: state IDLE; drain counter 0; dbg_rdata 0; dbg_ready 0; dbg_rvalid 0; core_stall 0.
REQ-021 Reset asserted in any state SHALL abort the access; a pending register write is not performed if reset coincides with ACCESS.

Configuration
REQ-022 Macro DEBUG_REG_ARBITER_X0_GUARD_EN.
- Defined: a debug write with dbg_addr=0 SHALL drive rf_enable=0 and still complete the handshake, and a debug read of address 0 SHALL return 0.
- Undefined: address 0 is treated like any other register.

Structure
REQ-023 The FSM state enum (dbg_arb_state_t) SHALL live in types_pkg; instruction_t and word_t SHALL be reused from types_pkg.
REQ-024 The block SHALL be a single module with no sub-modules; the drain counter SHALL be inline.

Verification
REQ-025 Read: reg 5 = 0x1234_5678; debug read addr 5, drain_cycles=2 -> dbg_ready at cycle 3; dbg_rvalid with dbg_rdata=0x1234_5678 at cycle 4.
REQ-026 Write: debug write addr 7 data 0xDEAD_BEEF -> reg 7 = 0xDEAD_BEEF after ACCESS; core_stall high from cycle 1 through the RESP handshake.
REQ-027 Contention: core_enable=1 writing x3=0x11 in the same cycle as dbg_valid -> x3=0x11 committed in DRAIN; debug write to x3=0x22 applied afterwards; final x3=0x22.
REQ-028 Backpressure: dbg_rready low for 5 cycles -> dbg_rvalid and dbg_rdata held stable and core_stall held high; release -> IDLE next cycle.
REQ-029 Reset mid-ACCESS during a write to x9 -> x9 unchanged; all outputs at their REQ-020 values next cycle.
REQ-030 X0 guard (macro defined): debug write 0xFFFF_FFFF to addr 0 -> rf_enable=0; subsequent read of addr 0 returns 0.
